ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//   Fetch-side consumer of the next-PC produced by the branch unit. Holds the architectural PC and
//   fetches one instruction from instruction memory over a valid/ready request/response interface.
//   Delivers {inst, pc} to the decoder and waits for the resolved next PC before fetching again.
//   One instruction in flight at a time (multi-cycle core); sits between imem and IDU.
// PARAMETERS
//   PC_W      32             PC / fetch address width
//   INST_W    32             instruction width
//   RESET_PC  32'h8000_0000  PC loaded on reset
// PORTS
//   clk_i             in   1       clock, all state updates on rising edge
//   rst_n_i           in   1       asynchronous, active-low reset
//   npc_valid_i       in   1       resolved next PC available from the branch unit
//   npc_i             in   PC_W    resolved next PC
//   npc_ready_o       out  1       fetch accepts npc_i this cycle
//   imem_req_valid_o  out  1       fetch request valid
//   imem_req_ready_i  in   1       imem accepts request
//   imem_req_addr_o   out  PC_W    fetch address (= current PC)
//   imem_rsp_valid_i  in   1       instruction word returned
//   imem_rsp_data_i   in   INST_W  returned instruction word
//   inst_valid_o      out  1       instruction available to decoder
//   inst_ready_i      in   1       decoder accepts instruction
//   inst_o            out  INST_W  instruction to decoder
//   inst_pc_o         out  PC_W    PC of inst_o
//   inst_fault_o      out  1       instruction-address-misaligned; valid with inst_valid_o
//   fetch_cnt_o       out  32      count of instructions handed to decoder
// BEHAVIOUR
// - States: REQ, WAIT, HOLD, WAIT_NPC. Reset -> REQ; pc=RESET_PC, inst_o=0, inst_pc_o=0,
//   inst_fault_o=0, fetch_cnt_o=0; all valid/ready outputs 0 while rst_n_i low.
// - REQ: imem_req_valid_o=1, imem_req_addr_o=pc. Valid and address held stable until
//   imem_req_ready_i. On the handshake cycle -> WAIT.
// - WAIT: imem_req_valid_o=0. On imem_rsp_valid_i: capture inst_o=data, inst_pc_o=pc,
//   inst_fault_o=0 -> HOLD. Response never accepted in the same cycle as the request handshake.
// - HOLD: inst_valid_o=1; inst_o, inst_pc_o, inst_fault_o stable until inst_ready_i.
//   Handshake: fetch_cnt_o += 1 (wraps 0xFFFF_FFFF -> 0) -> WAIT_NPC.
// - WAIT_NPC: npc_ready_o=1 (combinational from state only, not from npc_valid_i).
//   On npc_valid_i: pc <= npc_i.
//   - npc_i[1:0]==0: -> REQ (new request issued the next cycle).
//   - npc_i[1:0]!=0: no memory request; inst_o=0, inst_pc_o=npc_i, inst_fault_o=1 -> HOLD.
// - npc_ready_o=0 in every state other than WAIT_NPC; npc_valid_i there is ignored (producer holds it).
// - imem_rsp_valid_i outside WAIT is ignored; no state or output change.
// - inst_valid_o and npc_ready_o are never asserted together.
// - Latency with all ready/valid immediate: npc handshake at T -> req valid T+1 -> rsp T+2 earliest
//   -> inst_valid_o T+3.
// - Reset asserted mid-operation (any state): immediate return to reset values; pc=RESET_PC.
//   A stale response arriving after reset release, before the new request handshake, is ignored (REQ).
// - pc updates only on an npc handshake or on reset. Arithmetic on PC is not performed here.
// TESTING
// - Reset release, req_ready=1, rsp 1 cycle later with 32'h0000_0013
//   -> req_addr=0x8000_0000; inst_valid_o with inst_o=0x13, inst_pc_o=0x8000_0000, fetch_cnt_o 0->1.
// - imem_req_ready_i low 3 cycles -> imem_req_valid_o and addr stable for 4 cycles; 1 handshake only.
// - inst_ready_i low 5 cycles in HOLD -> inst_o/inst_pc_o stable; npc_ready_o stays 0 throughout.
// - npc_i=0x8000_0010 in WAIT_NPC -> next request addr 0x8000_0010.
//   npc_i=0x8000_0002 -> no request; inst_fault_o=1, inst_pc_o=0x8000_0002, inst_o=0.
// - Spurious imem_rsp_valid_i in REQ/HOLD/WAIT_NPC -> no output change.
//   Reset pulsed in WAIT -> next request addr 0x8000_0000; late response ignored.
// - Preload fetch_cnt near wrap (0xFFFF_FFFF via 2^32 fetches or force) -> next delivery gives 0.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the architectural PC, issues one imem request at a time,
// presents {inst, pc} to the decoder and waits for the resolved next PC before fetching again.
module ifu_fetch #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h8000_0000)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              npc_valid_i,
  input  logic [PC_W-1:0]   npc_i,
  output logic              npc_ready_o,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [PC_W-1:0]   imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   inst_pc_o,
  output logic              inst_fault_o,
  output logic [31:0]       fetch_cnt_o
);

  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] S_REQ      = 2'd0;
  localparam logic [1:0] S_WAIT     = 2'd1;
  localparam logic [1:0] S_HOLD     = 2'd2;
  localparam logic [1:0] S_WAIT_NPC = 2'd3;

  logic [1:0]        r_state;
  logic [PC_W-1:0]   r_pc;
  logic [INST_W-1:0] r_inst;
  logic [PC_W-1:0]   r_inst_pc;
  logic              r_fault;
  logic [CNT_W-1:0]  r_fetch_cnt;
  logic              r_req_valid;
  logic              r_inst_valid;
  logic              r_npc_ready;

  logic [1:0]        w_state_nxt;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [INST_W-1:0] w_inst_nxt;
  logic [PC_W-1:0]   w_inst_pc_nxt;
  logic              w_fault_nxt;
  logic [CNT_W-1:0]  w_fetch_cnt_nxt;
  logic              w_req_valid_nxt;
  logic              w_inst_valid_nxt;
  logic              w_npc_ready_nxt;

  // State and datapath registers; handshake flags are registered copies of the next state
  // so every valid/ready is low during reset and for the first cycle after release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_fault      <= 1'b0;
      r_fetch_cnt  <= '0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_npc_ready  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      r_fault      <= w_fault_nxt;
      r_fetch_cnt  <= w_fetch_cnt_nxt;
      r_req_valid  <= w_req_valid_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_npc_ready  <= w_npc_ready_nxt;
    end
  end

  // Next-state and next-datapath decode; responses outside WAIT fall through untouched.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_inst_nxt      = r_inst;
    w_inst_pc_nxt   = r_inst_pc;
    w_fault_nxt     = r_fault;
    w_fetch_cnt_nxt = r_fetch_cnt;

    case (r_state)
      S_REQ: begin
        if (r_req_valid && imem_req_ready_i) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          w_inst_nxt    = imem_rsp_data_i;
          w_inst_pc_nxt = r_pc;
          w_fault_nxt   = 1'b0;
          w_state_nxt   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_inst_valid && inst_ready_i) begin
          w_fetch_cnt_nxt = r_fetch_cnt + CNT_W'(1);
          w_state_nxt     = S_WAIT_NPC;
        end
      end
      S_WAIT_NPC: begin
        if (r_npc_ready && npc_valid_i) begin
          w_pc_nxt = npc_i;
          if (npc_i[1:0] == 2'b00) begin
            w_state_nxt = S_REQ;
          end else begin
            // Misaligned target: report a fault to the decoder instead of fetching.
            w_inst_nxt    = '0;
            w_inst_pc_nxt = npc_i;
            w_fault_nxt   = 1'b1;
            w_state_nxt   = S_HOLD;
          end
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase

    w_req_valid_nxt  = (w_state_nxt == S_REQ);
    w_inst_valid_nxt = (w_state_nxt == S_HOLD);
    w_npc_ready_nxt  = (w_state_nxt == S_WAIT_NPC);
  end

  assign npc_ready_o      = r_npc_ready;
  assign imem_req_valid_o = r_req_valid;
  assign imem_req_addr_o  = r_pc;
  assign inst_valid_o     = r_inst_valid;
  assign inst_o           = r_inst;
  assign inst_pc_o        = r_inst_pc;
  assign inst_fault_o     = r_fault;
  assign fetch_cnt_o      = r_fetch_cnt;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch.
module tb_ifu_fetch;

  logic        clk;
  logic        rst_n;
  logic        npc_valid;
  logic [31:0] npc;
  logic        npc_ready;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic [31:0] fetch_cnt;

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;

  ifu_fetch dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .npc_valid_i      (npc_valid),
    .npc_i            (npc),
    .npc_ready_o      (npc_ready),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_req_addr_o  (req_addr),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .inst_valid_o     (inst_valid),
    .inst_ready_i     (inst_ready),
    .inst_o           (inst),
    .inst_pc_o        (inst_pc),
    .inst_fault_o     (inst_fault),
    .fetch_cnt_o      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count request handshakes seen on the imem interface.
  always @(posedge clk) begin
    if (rst_n && req_valid && req_ready) hs_cnt = hs_cnt + 1;
  end

  // inst_valid and npc_ready must never be high together.
  always @(negedge clk) begin
    if (rst_n && inst_valid && npc_ready) begin
      failures = failures + 1;
      $display("FAIL valid_ready_exclusive: inst_valid=%b npc_ready=%b at %0t", inst_valid, npc_ready, $time);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; npc_valid = 1'b0; npc = '0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0; inst_ready = 1'b0;
    step(); step();
    checks++; if ({req_valid, inst_valid, npc_ready} !== 3'b000) begin failures++; $display("FAIL reset_valids: got %b exp 000", {req_valid, inst_valid, npc_ready}); end
    checks++; if (inst !== 32'h0 || inst_pc !== 32'h0 || inst_fault !== 1'b0) begin failures++; $display("FAIL reset_inst: got %h/%h/%b exp 0/0/0", inst, inst_pc, inst_fault); end
    checks++; if (fetch_cnt !== 32'h0) begin failures++; $display("FAIL reset_cnt: got %h exp 0", fetch_cnt); end
    checks++; if (req_addr !== 32'h8000_0000) begin failures++; $display("FAIL reset_pc: got %h exp 80000000", req_addr); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_fetch();
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin failures++; $display("FAIL first_req: got %b/%h exp 1/80000000", req_valid, req_addr); end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    checks++; if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL wait_state: got req=%b inst=%b exp 0/0", req_valid, inst_valid); end
    rsp_valid = 1'b1; rsp_data = 32'h0000_0013;
    step();
    rsp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h13 || inst_pc !== 32'h8000_0000 || inst_fault !== 1'b0) begin failures++; $display("FAIL first_inst: got %b %h %h %b exp 1 00000013 80000000 0", inst_valid, inst, inst_pc, inst_fault); end
    checks++; if (fetch_cnt !== 32'h0) begin failures++; $display("FAIL cnt_before: got %h exp 0", fetch_cnt); end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    checks++; if (fetch_cnt !== 32'h1 || inst_valid !== 1'b0 || npc_ready !== 1'b1) begin failures++; $display("FAIL first_deliver: got cnt=%h iv=%b nr=%b exp 1/0/1", fetch_cnt, inst_valid, npc_ready); end
  endtask

  task automatic test_npc_and_stalls();
    // Spurious response in WAIT_NPC must be ignored.
    rsp_valid = 1'b1; rsp_data = 32'hAAAA_5555;
    step();
    rsp_valid = 1'b0;
    checks++; if (npc_ready !== 1'b1 || inst !== 32'h13 || inst_valid !== 1'b0) begin failures++; $display("FAIL spurious_npc_wait: got nr=%b inst=%h exp 1/00000013", npc_ready, inst); end
    npc_valid = 1'b1; npc = 32'h8000_0010;
    step();
    npc_valid = 1'b0;
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0010 || npc_ready !== 1'b0) begin failures++; $display("FAIL aligned_npc: got %b %h nr=%b exp 1 80000010 0", req_valid, req_addr, npc_ready); end
    // Request stalled three cycles: valid and address hold.
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0010) begin failures++; $display("FAIL req_stall_%0d: got %b %h exp 1 80000010", i, req_valid, req_addr); end
    end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL req_drop: got %b exp 0", req_valid); end
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    step();
    rsp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst !== 32'hDEAD_BEEF || inst_pc !== 32'h8000_0010) begin failures++; $display("FAIL second_inst: got %b %h %h exp 1 deadbeef 80000010", inst_valid, inst, inst_pc); end
    // Decoder stalls five cycles; a spurious response and an early npc arrive meanwhile.
    for (int i = 0; i < 5; i++) begin
      rsp_valid = (i == 1); rsp_data = 32'h1234_5678;
      npc_valid = (i == 3); npc = 32'h8000_0100;
      step();
      checks++; if (inst_valid !== 1'b1 || inst !== 32'hDEAD_BEEF || inst_pc !== 32'h8000_0010 || npc_ready !== 1'b0 || req_addr !== 32'h8000_0010) begin failures++; $display("FAIL hold_stall_%0d: got iv=%b %h %h nr=%b pc=%h", i, inst_valid, inst, inst_pc, npc_ready, req_addr); end
    end
    rsp_valid = 1'b0; npc_valid = 1'b0;
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    checks++; if (fetch_cnt !== 32'h2 || npc_ready !== 1'b1) begin failures++; $display("FAIL second_deliver: got cnt=%h nr=%b exp 2/1", fetch_cnt, npc_ready); end
  endtask

  task automatic test_misaligned();
    npc_valid = 1'b1; npc = 32'h8000_0002;
    step();
    npc_valid = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || inst !== 32'h0 || inst_pc !== 32'h8000_0002 || req_valid !== 1'b0) begin failures++; $display("FAIL misaligned: got iv=%b f=%b %h %h rv=%b exp 1 1 0 80000002 0", inst_valid, inst_fault, inst, inst_pc, req_valid); end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    checks++; if (fetch_cnt !== 32'h3 || npc_ready !== 1'b1) begin failures++; $display("FAIL fault_deliver: got cnt=%h nr=%b exp 3/1", fetch_cnt, npc_ready); end
    npc_valid = 1'b1; npc = 32'h8000_0020;
    step();
    npc_valid = 1'b0;
    // Spurious response while the request is still pending.
    rsp_valid = 1'b1; rsp_data = 32'h0000_0BAD;
    step();
    rsp_valid = 1'b0;
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0020 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h8000_0002) begin failures++; $display("FAIL spurious_req: got rv=%b %h iv=%b %h %h", req_valid, req_addr, inst_valid, inst, inst_pc); end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'h0000_0093;
    step();
    rsp_valid = 1'b0;
    checks++; if (inst !== 32'h93 || inst_pc !== 32'h8000_0020 || inst_fault !== 1'b0) begin failures++; $display("FAIL fault_clear: got %h %h %b exp 00000093 80000020 0", inst, inst_pc, inst_fault); end
  endtask

  task automatic test_reset_in_wait();
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    npc_valid = 1'b1; npc = 32'h8000_0040;
    step();
    npc_valid = 1'b0; req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    checks++; if (req_valid !== 1'b0 || fetch_cnt !== 32'h4) begin failures++; $display("FAIL pre_reset_wait: got rv=%b cnt=%h exp 0/4", req_valid, fetch_cnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (req_addr !== 32'h8000_0000 || fetch_cnt !== 32'h0 || inst !== 32'h0 || inst_pc !== 32'h0 || {req_valid, inst_valid, npc_ready} !== 3'b000) begin failures++; $display("FAIL mid_reset: got pc=%h cnt=%h %h %h v=%b", req_addr, fetch_cnt, inst, inst_pc, {req_valid, inst_valid, npc_ready}); end
    step();
    rst_n = 1'b1;
    rsp_valid = 1'b1; rsp_data = 32'h0000_0777;
    step();
    rsp_valid = 1'b0;
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000 || inst_valid !== 1'b0 || inst !== 32'h0) begin failures++; $display("FAIL stale_rsp: got rv=%b %h iv=%b %h exp 1 80000000 0 0", req_valid, req_addr, inst_valid, inst); end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'h0000_0113;
    step();
    rsp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h113 || inst_pc !== 32'h8000_0000 || fetch_cnt !== 32'h0) begin failures++; $display("FAIL post_reset_fetch: got %b %h %h cnt=%h", inst_valid, inst, inst_pc, fetch_cnt); end
  endtask

  task automatic test_cnt_wrap();
    force dut.r_fetch_cnt = 32'hFFFF_FFFF;
    step();
    release dut.r_fetch_cnt;
    step();
    checks++; if (fetch_cnt !== 32'hFFFF_FFFF || inst_valid !== 1'b1) begin failures++; $display("FAIL cnt_preload: got %h iv=%b exp ffffffff 1", fetch_cnt, inst_valid); end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    checks++; if (fetch_cnt !== 32'h0 || npc_ready !== 1'b1) begin failures++; $display("FAIL cnt_wrap: got %h nr=%b exp 0 1", fetch_cnt, npc_ready); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_npc_and_stalls();
    test_misaligned();
    test_reset_in_wait();
    test_cnt_wrap();
    checks++; if (hs_cnt !== 5) begin failures++; $display("FAIL req_handshakes: got %0d exp 5", hs_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
